// File: rtl/cm85_serial_cmp.sv
// cm85_serial_cmp: serial MS-slice-first magnitude comparator with valid/ready result port.
// Define CM85_SERIAL_CMP_SIGNED_EN for two's-complement operands (sign fix on the first slice).
module cm85_serial_cmp #(
    parameter int SLICE_W    = 5,
    parameter int MAX_SLICES = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [SLICE_W-1:0]                   in_a,
    input  logic [SLICE_W-1:0]                   in_b,
    input  logic                                 in_last,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic                                 out_gt,
    output logic                                 out_eq,
    output logic                                 out_lt,
    output logic [$clog2(MAX_SLICES+1)-1:0]      out_cnt,
    output logic                                 out_err
);
    localparam int CW = $clog2(MAX_SLICES+1);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
    typedef enum logic [1:0] {REL_EQ, REL_GT, REL_LT} rel_t;

    state_t state, state_nxt;
    rel_t rel, rel_nxt;
    logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
    logic err, err_nxt;
    logic accept, at_max;
    logic [SLICE_W-1:0] a_cmp, b_cmp;

    assign in_ready  = state != HOLD;
    assign accept    = in_valid && in_ready;
    assign cnt_inc   = cnt + CW'(1);
    assign at_max    = cnt_inc == CW'(MAX_SLICES);
    assign out_valid = state == HOLD;
    assign out_gt    = rel == REL_GT;
    assign out_eq    = rel == REL_EQ;
    assign out_lt    = rel == REL_LT;
    assign out_cnt   = cnt;
    assign out_err   = err;

`ifdef CM85_SERIAL_CMP_SIGNED_EN
    // Flipping the sign bit maps two's complement onto unsigned order; only the first slice carries it.
    logic [SLICE_W-1:0] sign_flip;
    assign sign_flip = {(state == IDLE), {(SLICE_W-1){1'b0}}};
    assign a_cmp = in_a ^ sign_flip;
    assign b_cmp = in_b ^ sign_flip;
`else
    assign a_cmp = in_a;
    assign b_cmp = in_b;
`endif

    always_comb begin
        state_nxt = state;
        rel_nxt   = rel;
        cnt_nxt   = cnt;
        err_nxt   = err;
        if (accept) begin
            rel_nxt   = rel != REL_EQ ? rel : a_cmp > b_cmp ? REL_GT : a_cmp < b_cmp ? REL_LT : REL_EQ;
            cnt_nxt   = cnt_inc;
            err_nxt   = at_max && !in_last;
            state_nxt = (in_last || at_max) ? HOLD : ACCUM;
        end else if (state == HOLD && out_ready) begin
            state_nxt = IDLE;
            rel_nxt   = REL_EQ;
            cnt_nxt   = '0;
            err_nxt   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            rel   <= REL_EQ;
            cnt   <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            rel   <= rel_nxt;
            cnt   <= cnt_nxt;
            err   <= err_nxt;
        end
    end
endmodule
